rx_os_collector: RTL and testbench

Per-lane ordered-set collector for the receive path, sitting directly upstream of the receive LTSSM. It hunts each lane's decoded 8b/10b symbol stream for COM and assembles 16 consecutive symbols into a 128-bit ordered set. It then deskews across the configured lanes and presents all lanes together as one wide `orderedSets` bus with a single-cycle `validOrderedSets` strobe. Gen1/Gen2 (8-bit PIPE, one symbol per lane per clock) only.

---
 rtl/rx_os_collector.sv | 167 ++++++++++++++++
 tb/tb_rx_os_collector.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_os_collector.sv
// rx_os_collector: per-lane ordered-set collector with cross-lane deskew.
// Each lane hunts for COM, gathers 16 symbols into a 128-bit buffer and waits
// in DONE. When every configured lane is DONE the group is released onto the
// wide orderedSets bus with a one-cycle validOrderedSets strobe. A skew timer
// discards the group if the lanes finish too far apart.
// Handshake: there is no backpressure. validOrderedSets is a one-cycle strobe
// that marks orderedSets as freshly updated; orderedSets holds until the next
// release. rxValid qualifies rxData/rxDataK per lane on every rising edge.
module rx_os_collector #(
  parameter int LANES    = 16,
  parameter int SKEW_MAX = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES*8-1:0]     rxData,
  input  logic [LANES-1:0]       rxDataK,
  input  logic [LANES-1:0]       rxValid,
  input  logic [4:0]             numberOfDetectedLanes,
  output logic [LANES*128-1:0]   orderedSets,
  output logic                   validOrderedSets,
  output logic [LANES-1:0]       laneError,
  output logic                   skewError,
  output logic [LANES*2-1:0]     laneStateDbg
);

  localparam int SKW = $clog2(SKEW_MAX + 1);
  localparam logic [7:0] COM = 8'hBC;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } laneState_t;

  laneState_t     laneState [LANES];
  logic [3:0]     symCount  [LANES];
  logic [127:0]   laneBuf   [LANES];
  logic [4:0]     prevLanes;
  logic [SKW-1:0] skewCnt;

  logic [LANES-1:0] laneUsed;
  logic             anyDone;
  logic             allDone;
  logic             laneCountChange;
  logic             skewExpired;
  int               effLanes;

  // Effective lane count and group-level DONE summary over the configured lanes.
  always_comb begin
    effLanes = (int'(numberOfDetectedLanes) > LANES) ? LANES : int'(numberOfDetectedLanes);
    anyDone  = 1'b0;
    allDone  = (effLanes != 0);
    laneUsed = '0;
    for (int i = 0; i < LANES; i++) begin
      laneUsed[i] = (i < effLanes);
      if (laneUsed[i]) begin
        if (laneState[i] == DONE) anyDone = 1'b1;
        else                      allDone = 1'b0;
      end
    end
    laneCountChange = (numberOfDetectedLanes != prevLanes);
    // The counter only holds SKEW_MAX while a lane is waiting; a release in
    // the same cycle takes priority because allDone masks the expiry.
    skewExpired = anyDone && !allDone && (skewCnt == SKW'(SKEW_MAX));
  end

  // Per-lane state as a flat debug vector, two bits per lane.
  always_comb begin
    laneStateDbg = '0;
    for (int i = 0; i < LANES; i++) begin
      laneStateDbg[i*2 +: 2] = laneState[i];
    end
  end

  // Lane FSMs, group release, skew timer and registered output pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LANES; i++) begin
        laneState[i] <= HUNT;
        symCount[i]  <= 4'd0;
        laneBuf[i]   <= '0;
      end
      orderedSets      <= '0;
      validOrderedSets <= 1'b0;
      laneError        <= '0;
      skewError        <= 1'b0;
      skewCnt          <= '0;
      prevLanes        <= '0;
    end else begin
      validOrderedSets <= 1'b0;
      laneError        <= '0;
      skewError        <= 1'b0;
      prevLanes        <= numberOfDetectedLanes;

      if (laneCountChange) begin
        // Reconfiguration flushes silently.
        for (int i = 0; i < LANES; i++) begin
          laneState[i] <= HUNT;
          symCount[i]  <= 4'd0;
        end
        skewCnt <= '0;
      end else if (allDone) begin
        // Release: unused lanes present zeros.
        for (int i = 0; i < LANES; i++) begin
          orderedSets[i*128 +: 128] <= laneUsed[i] ? laneBuf[i] : 128'h0;
          laneState[i] <= HUNT;
          symCount[i]  <= 4'd0;
        end
        validOrderedSets <= 1'b1;
        skewCnt          <= '0;
      end else if (skewExpired) begin
        for (int i = 0; i < LANES; i++) begin
          laneState[i] <= HUNT;
          symCount[i]  <= 4'd0;
        end
        skewError <= 1'b1;
        skewCnt   <= '0;
      end else begin
        if (anyDone && (skewCnt != SKW'(SKEW_MAX))) skewCnt <= skewCnt + SKW'(1);
        for (int i = 0; i < LANES; i++) begin
          if (!laneUsed[i]) begin
            laneState[i] <= HUNT;
            symCount[i]  <= 4'd0;
          end else begin
            case (laneState[i])
              HUNT: begin
                if (rxValid[i] && rxDataK[i] && (rxData[i*8 +: 8] == COM)) begin
                  laneBuf[i][7:0] <= COM;
                  symCount[i]     <= 4'd1;
                  laneState[i]    <= COLLECT;
                end
              end
              COLLECT: begin
                if (!rxValid[i]) begin
                  laneState[i] <= HUNT;
                  symCount[i]  <= 4'd0;
                  laneError[i] <= 1'b1;
                end else if (rxDataK[i] && (rxData[i*8 +: 8] == COM)) begin
                  // A fresh COM restarts the set from symbol 0.
                  laneBuf[i][7:0] <= COM;
                  symCount[i]     <= 4'd1;
                  laneError[i]    <= 1'b1;
                end else begin
                  laneBuf[i][{symCount[i], 3'b000} +: 8] <= rxData[i*8 +: 8];
                  if (symCount[i] == 4'd15) begin
                    laneState[i] <= DONE;
                    symCount[i]  <= 4'd0;
                  end else begin
                    symCount[i] <= symCount[i] + 4'd1;
                  end
                end
              end
              DONE: begin
                // Hold the buffer until the group releases or is discarded.
              end
              default: begin
                laneState[i] <= HUNT;
                symCount[i]  <= 4'd0;
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_os_collector.sv
// Testbench for rx_os_collector: directed scenarios plus randomized rounds,
// checked every cycle against a queue-based behavioural model.
module tb_rx_os_collector;

  localparam int LANES    = 16;
  localparam int SKEW_MAX = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [LANES*8-1:0]   rxData;
  logic [LANES-1:0]     rxDataK;
  logic [LANES-1:0]     rxValid;
  logic [4:0]           numberOfDetectedLanes;
  logic [LANES*128-1:0] orderedSets;
  logic                 validOrderedSets;
  logic [LANES-1:0]     laneError;
  logic                 skewError;
  logic [LANES*2-1:0]   laneStateDbg;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rx_os_collector #(.LANES(LANES), .SKEW_MAX(SKEW_MAX)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .rxData                (rxData),
    .rxDataK               (rxDataK),
    .rxValid               (rxValid),
    .numberOfDetectedLanes (numberOfDetectedLanes),
    .orderedSets           (orderedSets),
    .validOrderedSets      (validOrderedSets),
    .laneError             (laneError),
    .skewError             (skewError),
    .laneStateDbg          (laneStateDbg)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  // ---------------- stimulus queues ----------------
  typedef struct packed {
    logic [7:0] d;
    logic       k;
    logic       v;
  } sym_t;

  sym_t lane_q [LANES][$];

  // ---------------- reference model state ----------------
  logic [7:0]   m_q [LANES][$];   // symbols gathered so far per lane
  int           m_age;
  logic [4:0]   m_prev_n;
  logic [127:0] m_os [LANES];
  logic         m_valid, m_skew;
  logic [LANES-1:0] m_lane_err;

  // ---------------- scoreboard ----------------
  logic [127:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobe_cnt = 0, skew_cnt = 0, lane_err_cnt = 0;
  int last_strobe_cyc = 0, last_skew_cyc = 0;

  task automatic check_val(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < LANES; l++) begin
      m_q[l].delete();
      m_os[l] = '0;
      lane_q[l].delete();
    end
    m_age = 0; m_prev_n = '0;
    m_valid = 0; m_skew = 0; m_lane_err = '0;
    exp_q.delete();
  endtask

  task automatic model_flush();
    for (int l = 0; l < LANES; l++) m_q[l].delete();
    m_age = 0;
  endtask

  // One receive clock of the specified behaviour, using the values just sampled.
  task automatic model_update();
    int n;
    bit all_done, any_done, com;
    logic [7:0] d;
    logic [127:0] v;
    n = (int'(numberOfDetectedLanes) > LANES) ? LANES : int'(numberOfDetectedLanes);
    m_valid = 0; m_skew = 0; m_lane_err = '0;
    all_done = (n > 0); any_done = 0;
    for (int l = 0; l < n; l++) begin
      if (m_q[l].size() == 16) any_done = 1;
      else all_done = 0;
    end
    if (numberOfDetectedLanes != m_prev_n) begin
      model_flush();
    end else if (all_done) begin
      for (int l = 0; l < LANES; l++) begin
        v = '0;
        if (l < n) for (int k = 0; k < 16; k++) v[k*8 +: 8] = m_q[l][k];
        m_os[l] = v;
        exp_q.push_back(v);
      end
      m_valid = 1;
      model_flush();
    end else if (any_done && m_age >= SKEW_MAX) begin
      m_skew = 1;
      model_flush();
    end else begin
      if (any_done && m_age < SKEW_MAX) m_age++;
      for (int l = 0; l < LANES; l++) begin
        d   = rxData[l*8 +: 8];
        com = rxValid[l] && rxDataK[l] && (d == 8'hBC);
        if (l >= n) m_q[l].delete();
        else if (m_q[l].size() == 16) ;
        else if (m_q[l].size() == 0) begin
          if (com) m_q[l].push_back(8'hBC);
        end else if (!rxValid[l]) begin
          m_q[l].delete();
          m_lane_err[l] = 1'b1;
        end else if (com) begin
          m_q[l].delete();
          m_q[l].push_back(8'hBC);
          m_lane_err[l] = 1'b1;
        end else begin
          m_q[l].push_back(d);
        end
      end
    end
    m_prev_n = numberOfDetectedLanes;
  endtask

  task automatic compare_outputs();
    check_val("valid", 128'(validOrderedSets), 128'(m_valid));
    check_val("skew_error", 128'(skewError), 128'(m_skew));
    check_val("lane_error", 128'(laneError), 128'(m_lane_err));
    for (int l = 0; l < LANES; l++)
      check_val($sformatf("os_hold_l%0d", l), orderedSets[l*128 +: 128], m_os[l]);
    if (validOrderedSets) begin
      strobe_cnt++;
      last_strobe_cyc = cyc;
      check_val("sb_has_entry", 128'(exp_q.size() >= LANES), 128'(1));
      if (exp_q.size() >= LANES)
        for (int l = 0; l < LANES; l++)
          check_val($sformatf("sb_slice_l%0d", l), orderedSets[l*128 +: 128], exp_q.pop_front());
    end
    if (skewError) begin skew_cnt++; last_skew_cyc = cyc; end
    for (int l = 0; l < LANES; l++) if (laneError[l]) lane_err_cnt++;
  endtask

  // ---------------- driver tasks ----------------
  function automatic sym_t idle_sym();
    sym_t e;
    e.d = 8'($urandom_range(0, 255));
    e.k = 1'($urandom_range(0, 1));
    e.v = 1'($urandom_range(0, 1));
    if (e.k && e.d == 8'hBC) e.k = 1'b0;
    return e;
  endfunction

  task automatic step();
    sym_t e;
    cyc++;
    for (int l = 0; l < LANES; l++) begin
      if (lane_q[l].size() > 0) e = lane_q[l].pop_front();
      else e = idle_sym();
      rxData[l*8 +: 8] = e.d;
      rxDataK[l] = e.k;
      rxValid[l] = e.v;
    end
    @(posedge clk);
    model_update();
    #1;
    compare_outputs();
  endtask

  task automatic push_sym(input int lane, input logic [7:0] d, input logic k, input logic v);
    sym_t e;
    e.d = d; e.k = k; e.v = v;
    lane_q[lane].push_back(e);
  endtask

  // COM plus 15 symbols after `delay` idle cycles; fixed payload is 01..0F.
  task automatic push_set(input int lane, input int delay, input bit fixed, input bit inject);
    sym_t e;
    for (int i = 0; i < delay; i++) lane_q[lane].push_back(idle_sym());
    push_sym(lane, 8'hBC, 1'b1, 1'b1);
    for (int k = 1; k < 16; k++) begin
      if (fixed) push_sym(lane, 8'(k), 1'b0, 1'b1);
      else begin
        e = idle_sym();
        e.v = 1'b1;
        if (inject && $urandom_range(0, 29) == 0) e.v = 1'b0;
        if (inject && $urandom_range(0, 29) == 0) begin e.d = 8'hBC; e.k = 1'b1; end
        lane_q[lane].push_back(e);
      end
    end
  endtask

  task automatic drain(input int tail);
    bit busy;
    int c;
    c = 0;
    busy = 1;
    while (busy && c < 400) begin
      busy = 0;
      for (int l = 0; l < LANES; l++) if (lane_q[l].size() > 0) busy = 1;
      if (busy) begin step(); c++; end
    end
    if (busy) begin
      check_val("drain_timeout", 128'(1), 128'(0));
      for (int l = 0; l < LANES; l++) lane_q[l].delete();
    end
    repeat (tail) step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) step();
  endtask

  // ---------------- main sequence ----------------
  int s0, k0, e0, com_cyc;
  logic [127:0] ts1_l0;

  initial begin
    rxData = '0; rxDataK = '0; rxValid = '0;
    numberOfDetectedLanes = 5'd4;
    reset = 1'b0;
    model_reset();
    #1;
    check_val("reset_valid", 128'(validOrderedSets), 128'(0));
    check_val("reset_skew", 128'(skewError), 128'(0));
    check_val("reset_lane_err", 128'(laneError), 128'(0));
    check_val("reset_os_l0", orderedSets[127:0], 128'h0);
    do_reset();

    // Aligned TS1 on four lanes.
    s0 = strobe_cnt;
    com_cyc = cyc + 1;
    for (int l = 0; l < 4; l++) push_set(l, 0, 1, 0);
    drain(4);
    ts1_l0 = 128'h0F0E0D0C0B0A090807060504030201BC;
    check_val("ts1_strobes", 128'(strobe_cnt - s0), 128'(1));
    check_val("ts1_latency", 128'(last_strobe_cyc - com_cyc), 128'(16));
    check_val("ts1_lane0", orderedSets[127:0], ts1_l0);
    check_val("ts1_lane3", orderedSets[3*128 +: 128], ts1_l0);
    check_val("ts1_lane4", orderedSets[4*128 +: 128], 128'h0);

    // Skew within limit: lane1 starts five cycles late.
    numberOfDetectedLanes = 5'd2;
    repeat (3) step();
    s0 = strobe_cnt; k0 = skew_cnt;
    push_set(0, 0, 0, 0);
    push_set(1, 5, 0, 0);
    drain(4);
    check_val("skew_ok_strobes", 128'(strobe_cnt - s0), 128'(1));
    check_val("skew_ok_no_err", 128'(skew_cnt - k0), 128'(0));

    // Skew exceeded: lane1 silent. Lane0 DONE after edge com+15, timer hits
    // SKEW_MAX eight edges later, discard pulse registered on the next edge.
    s0 = strobe_cnt; k0 = skew_cnt;
    com_cyc = cyc + 1;
    push_set(0, 0, 0, 0);
    drain(14);
    check_val("skew_bad_err", 128'(skew_cnt - k0), 128'(1));
    check_val("skew_bad_time", 128'(last_skew_cyc - com_cyc), 128'(15 + SKEW_MAX + 1));
    check_val("skew_bad_no_strobe", 128'(strobe_cnt - s0), 128'(0));
    push_set(0, 0, 0, 0);
    push_set(1, 0, 0, 0);
    drain(4);
    check_val("skew_recollect", 128'(strobe_cnt - s0), 128'(1));

    // Embedded COM at index 6, then valid drop at index 10.
    numberOfDetectedLanes = 5'd1;
    repeat (3) step();
    s0 = strobe_cnt; e0 = lane_err_cnt;
    push_sym(0, 8'hBC, 1'b1, 1'b1);
    for (int k = 1; k < 6; k++) push_sym(0, 8'(k), 1'b0, 1'b1);
    push_sym(0, 8'hBC, 1'b1, 1'b1);
    for (int k = 1; k < 10; k++) push_sym(0, 8'h20 + 8'(k), 1'b0, 1'b1);
    push_sym(0, 8'h00, 1'b0, 1'b0);
    push_set(0, 3, 1, 0);
    drain(4);
    check_val("emb_lane_errs", 128'(lane_err_cnt - e0), 128'(2));
    check_val("emb_strobes", 128'(strobe_cnt - s0), 128'(1));
    check_val("emb_lane0", orderedSets[127:0], ts1_l0);

    // Asynchronous reset while lane0 is at index 9.
    push_set(0, 0, 0, 0);
    repeat (9) step();
    #2 reset = 1'b0;
    #1;
    check_val("arst_valid", 128'(validOrderedSets), 128'(0));
    check_val("arst_lane_err", 128'(laneError), 128'(0));
    check_val("arst_os_l0", orderedSets[127:0], 128'h0);
    check_val("arst_dbg", 128'(laneStateDbg), 128'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) step();
    s0 = strobe_cnt;
    com_cyc = cyc + 1;
    push_set(0, 0, 0, 0);
    drain(4);
    check_val("arst_strobes", 128'(strobe_cnt - s0), 128'(1));
    check_val("arst_latency", 128'(last_strobe_cyc - com_cyc), 128'(16));

    // Lane-count change mid-collection flushes without errors.
    numberOfDetectedLanes = 5'd4;
    repeat (3) step();
    e0 = lane_err_cnt; k0 = skew_cnt; s0 = strobe_cnt;
    for (int l = 0; l < 4; l++) push_set(l, 0, 0, 0);
    repeat (6) step();
    numberOfDetectedLanes = 5'd2;
    for (int l = 0; l < LANES; l++) lane_q[l].delete();
    repeat (5) step();
    check_val("nchg_no_lane_err", 128'(lane_err_cnt - e0), 128'(0));
    check_val("nchg_no_skew", 128'(skew_cnt - k0), 128'(0));
    check_val("nchg_no_strobe", 128'(strobe_cnt - s0), 128'(0));
    push_set(0, 0, 1, 0);
    push_set(1, 0, 1, 0);
    drain(4);
    check_val("nchg_strobes", 128'(strobe_cnt - s0), 128'(1));
    check_val("nchg_lane1", orderedSets[128 +: 128], ts1_l0);
    check_val("nchg_lane2", orderedSets[2*128 +: 128], 128'h0);

    // Randomized rounds, including N = 0, N > LANES, skew beyond limit and
    // injected valid drops / embedded COMs.
    for (int r = 0; r < 30; r++) begin
      int n;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 6))
          0: numberOfDetectedLanes = 5'd0;
          1: numberOfDetectedLanes = 5'd1;
          2: numberOfDetectedLanes = 5'd3;
          3: numberOfDetectedLanes = 5'd8;
          4: numberOfDetectedLanes = 5'd16;
          5: numberOfDetectedLanes = 5'd20;
          default: numberOfDetectedLanes = 5'd31;
        endcase
      end
      n = (int'(numberOfDetectedLanes) > LANES) ? LANES : int'(numberOfDetectedLanes);
      for (int l = 0; l < n; l++) push_set(l, $urandom_range(0, 11), 0, 1);
      drain(14);
    end

    check_val("sb_drained", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
